// File: rtl/adder_result_accum.sv
// adder_result_accum
// Post-adder reduction stage. Accepts {cout, sum} result words over a
// valid/ready handshake, accumulates them into an ACC_W-bit total, counts
// samples and carry-outs, and closes a block after BLOCK_LEN samples or on
// flush. Each closed block is offered as one record on an output valid/ready
// handshake; no new samples are taken while a record is pending.
//
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   in_valid/ready  sample handshake (in_ready high only while accumulating)
//   in_sum, in_cout adder result word
//   flush           close the current partial block (ignored if it is empty)
//   out_valid/ready record handshake
//   out_total       sum of {cout, sum} over the block, modulo 2^ACC_W
//   out_carry_cnt   samples in the block with cout=1
//   out_count       samples in the block
//   out_overflow    accumulator wrapped at least once during the block
//
// ACC_W must be at least DATA_W+1 and BLOCK_LEN at least 1.
module adder_result_accum #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ACC_W     = 40,
  parameter int unsigned BLOCK_LEN = 16,
  parameter int unsigned CNT_W     = $clog2(BLOCK_LEN + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_sum,
  input  logic              in_cout,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_total,
  output logic [CNT_W-1:0]  out_carry_cnt,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_overflow
);

  localparam int unsigned SMP_W = DATA_W + 1;
  localparam int unsigned SUM_W = ACC_W + 1;

  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    DRAIN = 1'b1
  } state_t;

  state_t state, state_nxt;

  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] ccnt;
  logic             ovf;

  logic             accept;
  logic             close;
  logic [SMP_W-1:0] sample;
  logic [SUM_W-1:0] sum_ext;
  logic [ACC_W-1:0] acc_upd;
  logic             ovf_upd;
  logic [CNT_W-1:0] cnt_upd;
  logic [CNT_W-1:0] ccnt_upd;

  // Post-update block values, including a sample accepted this cycle
  always_comb begin
    accept   = in_valid && (state == ACCUM);
    sample   = {in_cout, in_sum};
    // One extra bit captures the wrap of the ACC_W-bit accumulator
    sum_ext  = {1'b0, acc} + SUM_W'(sample);
    acc_upd  = accept ? sum_ext[ACC_W-1:0] : acc;
    ovf_upd  = ovf | (accept & sum_ext[ACC_W]);
    cnt_upd  = cnt + CNT_W'(accept);
    ccnt_upd = ccnt + CNT_W'(accept & in_cout);
    // Empty flushes never close a block
    close    = (state == ACCUM) &&
               ((accept && (cnt_upd == CNT_W'(BLOCK_LEN))) ||
                (flush && ((cnt != '0) || accept)));
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ACCUM:   if (close)     state_nxt = DRAIN;
      DRAIN:   if (out_ready) state_nxt = ACCUM;
      default:                state_nxt = ACCUM;
    endcase
  end

  // State register and handshake flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ACCUM;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      in_ready  <= (state_nxt == ACCUM);
      out_valid <= (state_nxt == DRAIN);
    end
  end

  // Block accumulator and counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc  <= '0;
      cnt  <= '0;
      ccnt <= '0;
      ovf  <= 1'b0;
    end else if (close) begin
      acc  <= '0;
      cnt  <= '0;
      ccnt <= '0;
      ovf  <= 1'b0;
    end else begin
      acc  <= acc_upd;
      cnt  <= cnt_upd;
      ccnt <= ccnt_upd;
      ovf  <= ovf_upd;
    end
  end

  // Record registers; hold their last values after the handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_total     <= '0;
      out_count     <= '0;
      out_carry_cnt <= '0;
      out_overflow  <= 1'b0;
    end else if (close) begin
      out_total     <= acc_upd;
      out_count     <= cnt_upd;
      out_carry_cnt <= ccnt_upd;
      out_overflow  <= ovf_upd;
    end
  end

endmodule

// File: tb/tb_adder_result_accum.sv
// Bench for adder_result_accum: three instances cover the default build
// (BLOCK_LEN=16, ACC_W=40), a short block (BLOCK_LEN=4) and a narrow
// accumulator (ACC_W=34).
module tb_adder_result_accum;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        iv   [3];
  logic        ic   [3];
  logic        fl   [3];
  logic        ordy [3];
  logic [31:0] isum [3];

  logic        ir   [3];
  logic        ov   [3];
  logic        oovf [3];
  logic [39:0] tot  [3];
  logic [4:0]  cnt  [3];
  logic [4:0]  cc   [3];

  logic [39:0] tot0, tot1;
  logic [33:0] tot2;
  logic [4:0]  cnt0, cc0, cnt2, cc2;
  logic [2:0]  cnt1, cc1;

  int vecs = 0;
  int errs = 0;

  adder_result_accum u_def (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .in_sum(isum[0]),
    .in_cout(ic[0]), .flush(fl[0]), .out_valid(ov[0]), .out_ready(ordy[0]),
    .out_total(tot0), .out_carry_cnt(cc0), .out_count(cnt0), .out_overflow(oovf[0]));

  adder_result_accum #(.BLOCK_LEN(4)) u_bl4 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .in_sum(isum[1]),
    .in_cout(ic[1]), .flush(fl[1]), .out_valid(ov[1]), .out_ready(ordy[1]),
    .out_total(tot1), .out_carry_cnt(cc1), .out_count(cnt1), .out_overflow(oovf[1]));

  adder_result_accum #(.ACC_W(34)) u_a34 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .in_sum(isum[2]),
    .in_cout(ic[2]), .flush(fl[2]), .out_valid(ov[2]), .out_ready(ordy[2]),
    .out_total(tot2), .out_carry_cnt(cc2), .out_count(cnt2), .out_overflow(oovf[2]));

  assign tot[0] = tot0;
  assign tot[1] = tot1;
  assign tot[2] = 40'(tot2);
  assign cnt[0] = cnt0;
  assign cnt[1] = 5'(cnt1);
  assign cnt[2] = cnt2;
  assign cc[0]  = cc0;
  assign cc[1]  = 5'(cc1);
  assign cc[2]  = cc2;

  typedef struct {
    int unsigned d;
    logic        v;
    logic [31:0] s;
    logic        c;
    logic        f;
    logic        r;
    logic        e_ir;
    logic        e_ov;
    logic [39:0] e_tot;
    logic [4:0]  e_cnt;
    logic [4:0]  e_cc;
    logic        e_ovf;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(int unsigned d, logic v, logic [31:0] s, logic c, logic f,
                              logic r, logic e_ir, logic e_ov, logic [39:0] e_tot,
                              logic [4:0] e_cnt, logic [4:0] e_cc, logic e_ovf);
    vec_t x;
    x.d = d; x.v = v; x.s = s; x.c = c; x.f = f; x.r = r;
    x.e_ir = e_ir; x.e_ov = e_ov; x.e_tot = e_tot;
    x.e_cnt = e_cnt; x.e_cc = e_cc; x.e_ovf = e_ovf;
    return x;
  endfunction

  task automatic idle_all();
    for (int k = 0; k < 3; k++) begin
      iv[k] = 1'b0; ic[k] = 1'b0; fl[k] = 1'b0; ordy[k] = 1'b0; isum[k] = '0;
    end
  endtask

  task automatic drive(int unsigned d, logic v, logic [31:0] s, logic c, logic f, logic r);
    iv[d] = v; isum[d] = s; ic[d] = c; fl[d] = f; ordy[d] = r;
  endtask

  task automatic check(string name, int unsigned d, logic e_ir, logic e_ov, logic [39:0] e_tot,
                       logic [4:0] e_cnt, logic [4:0] e_cc, logic e_ovf);
    vecs++;
    if (ir[d] !== e_ir || ov[d] !== e_ov || tot[d] !== e_tot || cnt[d] !== e_cnt ||
        cc[d] !== e_cc || oovf[d] !== e_ovf) begin
      errs++;
      $display("FAIL %s dut%0d: got ir=%b ov=%b total=%h count=%0d carry=%0d ovf=%b, want ir=%b ov=%b total=%h count=%0d carry=%0d ovf=%b",
               name, d, ir[d], ov[d], tot[d], cnt[d], cc[d], oovf[d],
               e_ir, e_ov, e_tot, e_cnt, e_cc, e_ovf);
    end
  endtask

  // Reference model: block results from plain unbounded arithmetic
  task automatic run_random(int unsigned d, int n, int unsigned bl, int unsigned accw);
    longint unsigned tsum = 0;
    longint unsigned mask = (64'd1 << accw) - 64'd1;
    int unsigned     ns = 0, nc = 0;
    bit              pend = 1'b0;
    logic [39:0]     r_tot = '0;
    logic [4:0]      r_cnt = '0, r_cc = '0;
    logic            r_ovf = 1'b0;
    logic            v, c, f, r;
    logic [31:0]     s;
    for (int i = 0; i < n; i++) begin
      check("random", d, !pend, pend, r_tot, r_cnt, r_cc, r_ovf);
      v = ($urandom_range(0, 3) != 0);
      c = ($urandom_range(0, 1) == 1);
      f = ($urandom_range(0, 9) == 0);
      r = ($urandom_range(0, 1) == 1);
      s = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : 32'($urandom());
      drive(d, v, s, c, f, r);
      @(posedge clk);
      if (!pend) begin
        if (v) begin
          tsum += 64'({c, s});
          ns++;
          nc += int'(c);
        end
        if ((v && ns == bl) || (f && ns > 0)) begin
          r_tot = 40'(tsum & mask);
          r_ovf = ((tsum >> accw) != 0);
          r_cnt = 5'(ns);
          r_cc  = 5'(nc);
          tsum = 0; ns = 0; nc = 0;
          pend = 1'b1;
        end
      end else if (r) begin
        pend = 1'b0;
      end
      @(negedge clk);
    end
    drive(d, 1'b0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    idle_all();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 3; k++) check("reset", k, 1'b1, 1'b0, '0, '0, '0, 1'b0);

    // 4-sample block 1..4, then a stall with held input, then another block of carries
    tbl.push_back(mk(1, 1, 32'd1, 0, 0, 0, 1, 0, 40'd0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 32'd2, 0, 0, 0, 1, 0, 40'd0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 32'd3, 0, 0, 0, 1, 0, 40'd0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 32'd4, 0, 0, 0, 0, 1, 40'd10, 4, 0, 0));
    for (int k = 0; k < 5; k++)
      tbl.push_back(mk(1, 1, 32'd99, 0, 0, 0, 0, 1, 40'd10, 4, 0, 0));
    tbl.push_back(mk(1, 1, 32'd99, 0, 0, 1, 1, 0, 40'd10, 4, 0, 0));
    tbl.push_back(mk(1, 0, 32'd0, 0, 0, 0, 1, 0, 40'd10, 4, 0, 0));
    for (int k = 0; k < 3; k++)
      tbl.push_back(mk(1, 1, 32'hFFFF_FFFF, 1, 0, 0, 1, 0, 40'd10, 4, 0, 0));
    tbl.push_back(mk(1, 1, 32'hFFFF_FFFF, 1, 0, 0, 0, 1, 40'h7_FFFF_FFFC, 4, 4, 0));
    tbl.push_back(mk(1, 0, 32'd0, 0, 0, 1, 1, 0, 40'h7_FFFF_FFFC, 4, 4, 0));
    // Flush together with a sample, then an empty flush
    tbl.push_back(mk(0, 1, 32'd5, 0, 0, 0, 1, 0, 40'd0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 32'd7, 0, 0, 0, 1, 0, 40'd0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 32'd9, 0, 1, 0, 0, 1, 40'd21, 3, 0, 0));
    tbl.push_back(mk(0, 0, 32'd0, 0, 1, 1, 1, 0, 40'd21, 3, 0, 0));
    tbl.push_back(mk(0, 0, 32'd0, 0, 1, 0, 1, 0, 40'd21, 3, 0, 0));
    tbl.push_back(mk(0, 0, 32'd0, 0, 0, 0, 1, 0, 40'd21, 3, 0, 0));
    // Narrow accumulator wraps
    tbl.push_back(mk(2, 1, 32'hFFFF_FFFF, 1, 0, 0, 1, 0, 40'd0, 0, 0, 0));
    tbl.push_back(mk(2, 1, 32'hFFFF_FFFF, 1, 0, 0, 1, 0, 40'd0, 0, 0, 0));
    tbl.push_back(mk(2, 1, 32'hFFFF_FFFF, 1, 1, 0, 0, 1, 40'h1_FFFF_FFFD, 3, 3, 1));
    tbl.push_back(mk(2, 0, 32'd0, 0, 0, 1, 1, 0, 40'h1_FFFF_FFFD, 3, 3, 1));

    foreach (tbl[i]) begin
      @(negedge clk);
      idle_all();
      drive(tbl[i].d, tbl[i].v, tbl[i].s, tbl[i].c, tbl[i].f, tbl[i].r);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", i), tbl[i].d, tbl[i].e_ir, tbl[i].e_ov, tbl[i].e_tot,
            tbl[i].e_cnt, tbl[i].e_cc, tbl[i].e_ovf);
    end

    // Reset with one block partial (cnt=3) and another record pending
    @(negedge clk);
    idle_all();
    for (int k = 0; k < 4; k++) begin
      drive(1, 1'b1, 32'd1, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
    end
    idle_all();
    check("pre_rst_drain", 1, 1'b0, 1'b1, 40'd4, 5'd4, 5'd0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      drive(0, 1'b1, 32'd7, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
    end
    idle_all();
    #2 rst = 1'b1;
    #1;
    check("rst_partial", 0, 1'b1, 1'b0, '0, '0, '0, 1'b0);
    check("rst_drain", 1, 1'b1, 1'b0, '0, '0, '0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst0", 0, 1'b1, 1'b0, '0, '0, '0, 1'b0);
    check("post_rst1", 1, 1'b1, 1'b0, '0, '0, '0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      drive(1, 1'b1, 32'd2, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
    end
    idle_all();
    check("fresh_block1", 1, 1'b0, 1'b1, 40'd8, 5'd4, 5'd0, 1'b0);
    drive(0, 1'b1, 32'd3, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    idle_all();
    check("fresh_block0", 0, 1'b0, 1'b1, 40'h1_0000_0003, 5'd1, 5'd1, 1'b0);

    // Randomized phase against the reference model
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_random(0, 600, 16, 40);
    run_random(1, 600, 4, 40);
    run_random(2, 600, 16, 34);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
